// File: rtl/bc_buffer_mw_pkg.sv
// Shared types for the broadcast buffer: element width encoding, descriptor,
// per-bank state and the width helpers used by the element-select mux.
package bc_buffer_mw_pkg;

  localparam int unsigned ELEN  = 64;
  localparam int unsigned VlW   = 16;
  localparam int unsigned RepsW = 8;

  typedef logic [ELEN-1:0] elen_t;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  typedef struct packed {
    vew_e             vew;
    logic [VlW-1:0]   vl;
    logic [RepsW-1:0] reps;
  } bc_cfg_t;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILL    = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_DISCARD = 2'd3
  } bc_bank_state_e;

  // log2 of elements per 64-bit lane word
  function automatic logic [1:0] lg_epw(vew_e vew);
    return 2'(2'd3 - vew);
  endfunction

  // log2 of the element width in bits
  function automatic logic [2:0] lg_sew(vew_e vew);
    return 3'({1'b0, vew}) + 3'd3;
  endfunction

endpackage

// File: rtl/bc_buffer_mw_if.sv
// Handshake bundle between the load unit, the configuring sequencer and lane 0.
interface bc_buffer_mw_if import bc_buffer_mw_pkg::*; #(
  parameter int unsigned NrLanes = 4
);
  logic                           cfg_valid_i;
  logic                           cfg_ready_o;
  bc_cfg_t                        cfg_i;
  logic [NrLanes-1:0]             ldu_result_req_i;
  logic [NrLanes-1:0][ELEN-1:0]   ldu_result_wdata_i;
  logic [NrLanes-1:0]             ldu_result_gnt_o;
  logic [NrLanes-1:0]             ldu_result_final_gnt_o;
  logic                           bc_ready_i;
  logic                           bc_valid_o;
  elen_t                          bc_data_o;
  logic                           bc_last_o;
  logic                           bc_invalidate_i;
  logic                           busy_o;

  modport slave (
    input  cfg_valid_i, cfg_i, ldu_result_req_i, ldu_result_wdata_i,
           bc_ready_i, bc_invalidate_i,
    output cfg_ready_o, ldu_result_gnt_o, ldu_result_final_gnt_o,
           bc_valid_o, bc_data_o, bc_last_o, busy_o
  );

  modport master (
    output cfg_valid_i, cfg_i, ldu_result_req_i, ldu_result_wdata_i,
           bc_ready_i, bc_invalidate_i,
    input  cfg_ready_o, ldu_result_gnt_o, ldu_result_final_gnt_o,
           bc_valid_o, bc_data_o, bc_last_o, busy_o
  );
endinterface

// File: rtl/bc_buffer_mw_bank.sv
// One broadcast bank: beat storage, fill count, descriptor, replay counter,
// read index and the element-select mux. Pop/invalidate arrive pre-qualified
// from the top (pop implies valid and no invalidate).
module bc_buffer_mw_bank import bc_buffer_mw_pkg::*; #(
  parameter int unsigned NrLanes   = 4,
  parameter int unsigned BankDepth = 16,
  parameter int unsigned MaxReps   = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_we_i,
  input  bc_cfg_t                      cfg_i,
  input  logic                         wr_en_i,
  input  logic [NrLanes-1:0][ELEN-1:0] wdata_i,
  input  logic                         pop_i,
  input  logic                         inval_i,
  output bc_bank_state_e               state_o,
  output logic                         wr_done_o,
  output logic                         rd_valid_o,
  output logic                         rd_last_o,
  output logic                         rd_done_o,
  output elen_t                        rd_data_o
);

  localparam int unsigned LgL   = $clog2(NrLanes);
  localparam int unsigned CntW  = $clog2(BankDepth + 1);
  localparam int unsigned BeatW = $clog2(BankDepth);
  localparam int unsigned RepW  = $clog2(MaxReps + 1);
  localparam int unsigned VW1   = VlW + 1;

  bc_bank_state_e               state_q;
  logic [CntW-1:0]              cnt_q;
  vew_e                         vew_q;
  logic [VlW-1:0]               vl_q;
  logic [RepW-1:0]              reps_q;
  logic [VlW-1:0]               rd_idx_q;
  logic [NrLanes-1:0][ELEN-1:0] mem_q [BankDepth];

  // Geometry of one beat for the latched element width
  logic [4:0]     lg_bpe;
  logic [VW1-1:0] beats_need;
  assign lg_bpe     = 5'(LgL) + 5'(lg_epw(vew_q));
  assign beats_need = (VW1'(vl_q) + ((VW1'(1) << lg_bpe) - VW1'(1))) >> lg_bpe;
  assign wr_done_o  = wr_en_i && (VW1'(cnt_q) + VW1'(1) == beats_need);

  // Element select: beat, then lane, then slot within the lane word
  logic [VlW-1:0]  rd_beat, rd_m;
  logic [LgL-1:0]  rd_lane;
  logic [2:0]      rd_slot;
  logic [5:0]      rd_sh;
  elen_t           rd_word, rd_shifted;
  assign rd_beat    = rd_idx_q >> lg_bpe;
  assign rd_m       = rd_idx_q & ((VlW'(1) << lg_bpe) - VlW'(1));
  assign rd_lane    = rd_m[LgL-1:0];
  assign rd_slot    = 3'(rd_m >> LgL);
  assign rd_sh      = 6'(rd_slot) << lg_sew(vew_q);
  assign rd_word    = mem_q[rd_beat[BeatW-1:0]][rd_lane];
  assign rd_shifted = rd_word >> rd_sh;

  // Right-align and zero the bits above the element width
  always_comb begin
    rd_data_o = rd_shifted;
    unique case (vew_q)
      EW16:    rd_data_o = {48'd0, rd_shifted[15:0]};
      EW32:    rd_data_o = {32'd0, rd_shifted[31:0]};
      default: rd_data_o = rd_shifted;
    endcase
  end

  // Readable as soon as the beat holding rd_idx has landed
  assign rd_valid_o = (state_q == BANK_FILL || state_q == BANK_FULL) &&
                      (rd_beat < VlW'(cnt_q));
  assign rd_last_o  = (rd_idx_q == vl_q - VlW'(1));
  assign rd_done_o  = pop_i && rd_last_o && (reps_q == RepW'(1));
  assign state_o    = state_q;

  logic to_free;
  assign to_free = (state_q == BANK_FILL    && inval_i && wr_done_o) ||
                   (state_q == BANK_FULL    && (inval_i || rd_done_o)) ||
                   (state_q == BANK_DISCARD && wr_done_o);

  // Bank state, counters and descriptor
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= BANK_FREE;
      cnt_q    <= '0;
      vew_q    <= EW64;
      vl_q     <= '0;
      reps_q   <= '0;
      rd_idx_q <= '0;
    end else begin
      if (wr_en_i) cnt_q <= cnt_q + CntW'(1);
      if (pop_i) begin
        rd_idx_q <= rd_last_o ? '0 : rd_idx_q + VlW'(1);
        if (rd_last_o) reps_q <= reps_q - RepW'(1);
      end
      unique case (state_q)
        BANK_FREE: if (cfg_we_i) begin
          state_q <= BANK_FILL;
          vew_q   <= cfg_i.vew;
          vl_q    <= cfg_i.vl;
          reps_q  <= (cfg_i.reps == '0) ? RepW'(1) : RepW'(cfg_i.reps);
        end
        BANK_FILL: begin
          if (inval_i)        state_q <= wr_done_o ? BANK_FREE : BANK_DISCARD;
          else if (wr_done_o) state_q <= BANK_FULL;
        end
        BANK_FULL:    if (to_free) state_q <= BANK_FREE;
        BANK_DISCARD: if (to_free) state_q <= BANK_FREE;
        default:      state_q <= BANK_FREE;
      endcase
      if (inval_i) rd_idx_q <= '0;
      if (to_free) begin
        cnt_q    <= '0;
        rd_idx_q <= '0;
      end
    end
  end

  // Beat storage; discarded beats are never written
  always_ff @(posedge clk_i) begin
    if (wr_en_i && state_q == BANK_FILL) mem_q[cnt_q[BeatW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bc_buffer_mw.sv
// Broadcast buffer top: round-robin pointers, all-lanes grant and the read
// mux selecting the bank under rd_ptr.
module bc_buffer_mw import bc_buffer_mw_pkg::*; #(
  parameter int unsigned NrLanes   = 4,
  parameter int unsigned NrBanks   = 2,
  parameter int unsigned BankDepth = 16,
  parameter int unsigned MaxReps   = 15
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  bc_buffer_mw_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NrBanks);

  if (NrBanks < 2 || (NrBanks & (NrBanks - 1)) != 0) begin : g_bad_banks
    $error("NrBanks must be a power of two >= 2");
  end
  if (NrLanes < 2 || (NrLanes & (NrLanes - 1)) != 0) begin : g_bad_lanes
    $error("NrLanes must be a power of two >= 2");
  end

  logic [PtrW-1:0]    cfg_ptr_q, wr_ptr_q, rd_ptr_q;
  bc_bank_state_e     st [NrBanks];
  logic [NrBanks-1:0] wr_done, rd_valid, rd_last, rd_done, busy_vec;
  elen_t              rd_data [NrBanks];

  logic cfg_acc, grant, rd_vld, pop, inval_eff, rd_adv;

  assign bus.cfg_ready_o = (st[cfg_ptr_q] == BANK_FREE);
  assign cfg_acc         = bus.cfg_valid_i && bus.cfg_ready_o;

  // A beat is taken only when every lane offers it at once
  assign grant = (&bus.ldu_result_req_i) &&
                 (st[wr_ptr_q] == BANK_FILL || st[wr_ptr_q] == BANK_DISCARD);
  assign bus.ldu_result_gnt_o       = {NrLanes{grant}};
  assign bus.ldu_result_final_gnt_o = {NrLanes{grant}};

  // Invalidate masks the read side for the cycle it is asserted
  assign rd_vld    = rd_valid[rd_ptr_q] && !bus.bc_invalidate_i;
  assign pop       = rd_vld && bus.bc_ready_i;
  assign inval_eff = bus.bc_invalidate_i &&
                     (st[rd_ptr_q] == BANK_FILL || st[rd_ptr_q] == BANK_FULL);
  assign rd_adv    = inval_eff || rd_done[rd_ptr_q];

  assign bus.bc_valid_o = rd_vld;
  assign bus.bc_last_o  = rd_vld && rd_last[rd_ptr_q];
  assign bus.bc_data_o  = rd_vld ? rd_data[rd_ptr_q] : '0;
  assign bus.busy_o     = |busy_vec;

  for (genvar k = 0; k < NrBanks; k++) begin : g_bank
    bc_buffer_mw_bank #(
      .NrLanes  (NrLanes),
      .BankDepth(BankDepth),
      .MaxReps  (MaxReps)
    ) u_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .cfg_we_i  (cfg_acc && cfg_ptr_q == PtrW'(k)),
      .cfg_i     (bus.cfg_i),
      .wr_en_i   (grant && wr_ptr_q == PtrW'(k)),
      .wdata_i   (bus.ldu_result_wdata_i),
      .pop_i     (pop && rd_ptr_q == PtrW'(k)),
      .inval_i   (bus.bc_invalidate_i && rd_ptr_q == PtrW'(k)),
      .state_o   (st[k]),
      .wr_done_o (wr_done[k]),
      .rd_valid_o(rd_valid[k]),
      .rd_last_o (rd_last[k]),
      .rd_done_o (rd_done[k]),
      .rd_data_o (rd_data[k])
    );
    assign busy_vec[k] = (st[k] != BANK_FREE);
  end

  // Round-robin pointers; each moves on its own event
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_ptr_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (cfg_acc)           cfg_ptr_q <= cfg_ptr_q + PtrW'(1);
      if (wr_done[wr_ptr_q]) wr_ptr_q  <= wr_ptr_q + PtrW'(1);
      if (rd_adv)            rd_ptr_q  <= rd_ptr_q + PtrW'(1);
    end
  end

  // Descriptor sanity on acceptance
  a_vl_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cfg_acc |-> bus.cfg_i.vl != '0);
  a_vew_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cfg_acc |-> bus.cfg_i.vew != EW8);
  a_vl_fits : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cfg_acc |-> 32'(bus.cfg_i.vl) <= ((BankDepth * NrLanes) << lg_epw(bus.cfg_i.vew)));
  a_reps_fit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cfg_acc |-> 32'(bus.cfg_i.reps) <= MaxReps);

endmodule
